dm_bus_master: RTL

Data-side bus master that converts the CPU pipeline's data-memory requests into single-beat AXI4 read/write transactions. It generates `DM_stall` back to the pipeline hazard controller, freezing all pipeline registers until the bus access completes. It sits in the CPU wrapper between the MEM stage and the system interconnect, and is the producer of the stall that the hazard controller consumes.

---
 rtl/dm_bus_pkg.sv | 35 +++
 rtl/dm_bus_master_if.sv | 86 ++++++++
 rtl/dm_bus_master.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_bus_pkg.sv
//------------------------------------------------------------------------------
// dm_bus_pkg
//   Shared definitions for the data-side AXI4 bus master (dm_bus_master) and
//   its bus interface (dm_bus_master_if).
//
//   Contents:
//     dm_state_e  - bus master FSM state encoding
//     RESP_OKAY   - AXI OKAY response code
//     BURST_INCR  - AXI INCR burst type
//     SIZE_WORD   - AXI transfer size for a 32-bit beat
//     LEN_SINGLE  - AXI burst length field for a single beat
//     is_read()   - decodes the pipeline byte-enable vector into read/write
//------------------------------------------------------------------------------
package dm_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_RESP = 3'd4,
      ST_DONE    = 3'd5
   } dm_state_e;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [3:0] LEN_SINGLE = 4'd0;

   // An all-zero byte-enable vector from the MEM stage denotes a load.
   function automatic logic is_read(input logic [3:0] web);
      return (web == 4'b0000);
   endfunction

endpackage : dm_bus_pkg

// File: rtl/dm_bus_master_if.sv
//------------------------------------------------------------------------------
// dm_bus_master_if
//   Single-beat AXI4 bus between the data-side master and the interconnect.
//
//   Parameter:
//     ID_W - AXI ID width
//
//   Signals (direction seen from the master modport):
//     AW channel : AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID out; AWREADY in
//     W  channel : WDATA, WSTRB, WLAST, WVALID out; WREADY in
//     B  channel : BID, BRESP, BVALID in; BREADY out
//     AR channel : ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID out; ARREADY in
//     R  channel : RID, RDATA, RRESP, RLAST, RVALID in; RREADY out
//
//   Modports: master (bus master side), slave (interconnect side).
//------------------------------------------------------------------------------
interface dm_bus_master_if #(
   parameter int ID_W = 4
);

   // Write address channel
   logic [ID_W-1:0] AWID;
   logic [31:0]     AWADDR;
   logic [3:0]      AWLEN;
   logic [2:0]      AWSIZE;
   logic [1:0]      AWBURST;
   logic            AWVALID;
   logic            AWREADY;

   // Write data channel
   logic [31:0]     WDATA;
   logic [3:0]      WSTRB;
   logic            WLAST;
   logic            WVALID;
   logic            WREADY;

   // Write response channel
   logic [ID_W-1:0] BID;
   logic [1:0]      BRESP;
   logic            BVALID;
   logic            BREADY;

   // Read address channel
   logic [ID_W-1:0] ARID;
   logic [31:0]     ARADDR;
   logic [3:0]      ARLEN;
   logic [2:0]      ARSIZE;
   logic [1:0]      ARBURST;
   logic            ARVALID;
   logic            ARREADY;

   // Read data channel
   logic [ID_W-1:0] RID;
   logic [31:0]     RDATA;
   logic [1:0]      RRESP;
   logic            RLAST;
   logic            RVALID;
   logic            RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );

endinterface : dm_bus_master_if

// File: rtl/dm_bus_master.sv
//------------------------------------------------------------------------------
// dm_bus_master
//   Converts MEM-stage data-memory requests into single-beat AXI4 read/write
//   transactions and raises DM_stall to freeze the pipeline until the bus
//   access completes. Only one transaction is ever outstanding.
//
//   Parameters:
//     ID_W      - AXI ID width
//     MASTER_ID - constant driven on AWID/ARID
//
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset
//     DM_req    in   access request, held until DM_stall is low
//     DM_web    in   [3:0] byte write strobes, all-zero = read
//     DM_addr   in   [31:0] byte address
//     DM_wdata  in   [31:0] store data
//     DM_rdata  out  [31:0] load data, valid in the cycle DM_stall falls
//     DM_stall  out  pipeline freeze request
//     bus_err   out  sticky bus error flag
//     axi       dm_bus_master_if.master  AXI4 bus
//
//   Optional feature (macro DM_RESP_CHECK_EN):
//     defined   - a non-OKAY RRESP/BRESP sets bus_err (sticky until rst) and
//                 an erroring read returns DM_rdata = 0.
//     undefined - responses are ignored, bus_err = 0, DM_rdata takes RDATA.
//------------------------------------------------------------------------------
module dm_bus_master
   import dm_bus_pkg::*;
#(
   parameter int              ID_W      = 4,
   parameter logic [ID_W-1:0] MASTER_ID = ID_W'(1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    DM_req,
   input  logic [3:0]              DM_web,
   input  logic [31:0]             DM_addr,
   input  logic [31:0]             DM_wdata,
   output logic [31:0]             DM_rdata,
   output logic                    DM_stall,
   output logic                    bus_err,
   dm_bus_master_if.master         axi
);

   // State constants taken from the shared encoding.
   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] RD_ADDR = ST_RD_ADDR;
   localparam logic [2:0] RD_DATA = ST_RD_DATA;
   localparam logic [2:0] WR_REQ  = ST_WR_REQ;
   localparam logic [2:0] WR_RESP = ST_WR_RESP;
   localparam logic [2:0] DONE    = ST_DONE;

   logic [2:0]  state_reg;
   logic [2:0]  state_next;

   // Request captured in IDLE; drives the bus for the whole transaction so
   // address/data stay stable regardless of what the pipeline does.
   logic [31:0] addr_reg;
   logic [3:0]  web_reg;
   logic [31:0] wdata_reg;

   // Per-channel completion flags for the write address and write data.
   logic        aw_done_reg;
   logic        w_done_reg;

   logic [31:0] rdata_reg;

   logic        accept;
   logic        aw_fire;
   logic        w_fire;
   logic        r_fire;
   logic        b_fire;

   // Identification/last fields are not needed with a single outstanding beat.
   logic        unused_bits;
   assign unused_bits = ^{axi.BID, axi.RID, axi.RLAST, axi.RRESP, axi.BRESP};

   //---------------------------------------------------------------------------
   // Handshake decode. VALIDs are functions of registered state only, so none
   // of them depends combinationally on a READY.
   //---------------------------------------------------------------------------
   assign accept  = (state_reg == IDLE) && DM_req;
   assign aw_fire = axi.AWVALID && axi.AWREADY;
   assign w_fire  = axi.WVALID  && axi.WREADY;
   assign r_fire  = axi.RVALID  && axi.RREADY;
   assign b_fire  = axi.BVALID  && axi.BREADY;

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (DM_req) begin
               state_next = is_read(DM_web) ? RD_ADDR : WR_REQ;
            end
         end
         RD_ADDR: begin
            if (axi.ARREADY) begin
               state_next = RD_DATA;
            end
         end
         RD_DATA: begin
            if (axi.RVALID) begin
               state_next = DONE;
            end
         end
         WR_REQ: begin
            // Address and data may complete in either order or together.
            if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
               state_next = WR_RESP;
            end
         end
         WR_RESP: begin
            if (axi.BVALID) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // DM_req is still the completed instruction here; never reissue.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         addr_reg    <= 32'h0;
         web_reg     <= 4'h0;
         wdata_reg   <= 32'h0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         rdata_reg   <= 32'h0;
      end else begin
         state_reg <= state_next;

         if (accept) begin
            addr_reg    <= DM_addr;
            web_reg     <= DM_web;
            wdata_reg   <= DM_wdata;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
         end else begin
            if (aw_fire) begin
               aw_done_reg <= 1'b1;
            end
            if (w_fire) begin
               w_done_reg <= 1'b1;
            end
         end

         if (r_fire) begin
`ifdef DM_RESP_CHECK_EN
            rdata_reg <= (axi.RRESP == RESP_OKAY) ? axi.RDATA : 32'h0;
`else
            rdata_reg <= axi.RDATA;
`endif
         end
      end
   end

`ifdef DM_RESP_CHECK_EN
   // Sticky error: any non-OKAY response seen since the last reset.
   logic bus_err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_err_reg <= 1'b0;
      end else if ((r_fire && (axi.RRESP != RESP_OKAY)) ||
                   (b_fire && (axi.BRESP != RESP_OKAY))) begin
         bus_err_reg <= 1'b1;
      end
   end

   assign bus_err = bus_err_reg;
`else
   assign bus_err = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Pipeline side
   //---------------------------------------------------------------------------
   // Stall starts combinationally in the request cycle so the pipeline freezes
   // before the MEM-stage instruction can advance; it drops only in DONE.
   assign DM_stall = accept || ((state_reg != IDLE) && (state_reg != DONE));
   assign DM_rdata = rdata_reg;

   //---------------------------------------------------------------------------
   // AXI outputs
   //---------------------------------------------------------------------------
   assign axi.AWID    = MASTER_ID;
   assign axi.AWADDR  = addr_reg;
   assign axi.AWLEN   = LEN_SINGLE;
   assign axi.AWSIZE  = SIZE_WORD;
   assign axi.AWBURST = BURST_INCR;
   assign axi.AWVALID = (state_reg == WR_REQ) && !aw_done_reg;

   assign axi.WDATA   = wdata_reg;
   assign axi.WSTRB   = web_reg;
   assign axi.WLAST   = 1'b1;
   assign axi.WVALID  = (state_reg == WR_REQ) && !w_done_reg;

   assign axi.BREADY  = (state_reg == WR_RESP);

   assign axi.ARID    = MASTER_ID;
   assign axi.ARADDR  = addr_reg;
   assign axi.ARLEN   = LEN_SINGLE;
   assign axi.ARSIZE  = SIZE_WORD;
   assign axi.ARBURST = BURST_INCR;
   assign axi.ARVALID = (state_reg == RD_ADDR);

   assign axi.RREADY  = (state_reg == RD_DATA);

endmodule : dm_bus_master
